// File: rtl/shift_register_siso_pkg.sv
// Shared constants for the serial-in / serial-out delay line.
package shift_register_siso_pkg;

  localparam int unsigned DEPTH_DEFAULT     = 32'd4;
  localparam logic        RESET_VAL_DEFAULT = 1'b0;

endpackage

// File: rtl/shift_register_siso_dff_async_rst.sv
// Single D flip-flop with asynchronous active-high reset; one stage of the delay line.
module shift_register_siso_dff_async_rst
  import shift_register_siso_pkg::*;
#(
  parameter logic RESET_VAL = RESET_VAL_DEFAULT
) (
  input  logic clk,
  input  logic rs,
  input  logic d,
  output logic q
);

  // Stage register: reset wins immediately, otherwise capture d on the rising edge.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_register_siso.sv
// Serial-in / serial-out shift register: DEPTH chained flops, Q taken straight from the last one.
module shift_register_siso
  import shift_register_siso_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter logic        RESET_VAL = RESET_VAL_DEFAULT
) (
  input  logic clk,
  input  logic rs,
  input  logic D,
  output logic Q
);

  logic [DEPTH-1:0] stage_s;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic link_s;

    // Stage 0 is fed from the serial input, every other stage from its predecessor.
    if (i == 0) begin : g_head
      assign link_s = D;
    end else begin : g_link
      assign link_s = stage_s[i-1];
    end

    shift_register_siso_dff_async_rst #(
      .RESET_VAL (RESET_VAL)
    ) u_dff (
      .clk (clk),
      .rs  (rs),
      .d   (link_s),
      .q   (stage_s[i])
    );
  end

  assign Q = stage_s[DEPTH-1];

endmodule

// File: tb/tb_shift_register_siso.sv
// Scoreboard bench: DEPTH=4 (hand-computed expectations) plus DEPTH=1 and DEPTH=8 (delay model) share D and rs.
module tb_shift_register_siso;

  typedef struct packed {
    logic e4;
    logic e1;
    logic e8;
  } exp_t;

  logic clk_s = 1'b0;
  logic rs_s;
  logic d_s;
  logic q4_s;
  logic q1_s;
  logic q8_s;

  exp_t edge_q[$];
  exp_t async_q[$];
  logic hist[$];
  event async_ev;

  int vectors    = 0;
  int miscompares = 0;

  always #50 clk_s = ~clk_s;

  shift_register_siso #(.DEPTH(4), .RESET_VAL(1'b0)) u_dut4 (
    .clk (clk_s), .rs (rs_s), .D (d_s), .Q (q4_s)
  );
  shift_register_siso #(.DEPTH(1), .RESET_VAL(1'b0)) u_dut1 (
    .clk (clk_s), .rs (rs_s), .D (d_s), .Q (q1_s)
  );
  shift_register_siso #(.DEPTH(8), .RESET_VAL(1'b0)) u_dut8 (
    .clk (clk_s), .rs (rs_s), .D (d_s), .Q (q8_s)
  );

  // Value expected on Q of a depth-n chain: the bit captured n edges ago, or the reset value.
  function automatic logic model(input int n);
    if (hist.size() >= n) return hist[hist.size() - n];
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, " depth4"}, q4_s, e.e4);
    check({tag, " depth1"}, q1_s, e.e1);
    check({tag, " depth8"}, q8_s, e.e8);
  endtask

  // Drive D at the current falling edge, queue what each chain shows after the next rising edge.
  task automatic drive(input logic d, input logic e4);
    exp_t e;
    d_s = d;
    hist.push_back(d);
    e.e4 = e4;
    e.e1 = model(1);
    e.e8 = model(8);
    edge_q.push_back(e);
    @(negedge clk_s);
  endtask

  task automatic async_expect_zero();
    exp_t e;
    e = '{e4: 1'b0, e1: 1'b0, e8: 1'b0};
    async_q.push_back(e);
    -> async_ev;
  endtask

  // Edge monitor: after every rising edge with a queued expectation, compare all three outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_s);
      #1;
      if (edge_q.size() > 0) begin
        e = edge_q.pop_front();
        check_all("edge", e);
      end
    end
  end

  // Async monitor: checks Q between clock edges, right after reset activity.
  initial begin
    exp_t e;
    forever begin
      @(async_ev);
      #1;
      if (async_q.size() > 0) begin
        e = async_q.pop_front();
        check_all("async", e);
      end
    end
  end

  initial begin
    logic seq_d[10];
    logic seq_e[10];
    logic pulse_e[7];
    logic alt_e[12];

    seq_d   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    seq_e   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    pulse_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    alt_e   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset hold with D unknown; the edge at 50 must not load anything.
    rs_s = 1'b1;
    d_s  = 1'bx;
    edge_q.push_back('{e4: 1'b0, e1: 1'b0, e8: 1'b0});
    #10;
    async_expect_zero();
    @(negedge clk_s);

    // Release at t=100 and run the latency sequence (edges 150..1050).
    rs_s = 1'b0;
    hist.delete();
    for (int i = 0; i < 10; i++) drive(seq_d[i], seq_e[i]);

    // Chain now holds all ones; pulse reset for 30 ns between edges.
    #10;
    rs_s = 1'b1;
    async_expect_zero();
    #30;
    rs_s = 1'b0;
    hist.delete();
    async_expect_zero();
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);

    // Flush with zeros, then a single-edge pulse.
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive((i == 0) ? 1'b1 : 1'b0, pulse_e[i]);

    // Alternating 0101... for 12 edges.
    for (int i = 0; i < 12; i++) drive(i[0], alt_e[i]);

    #200;
    vectors++;
    if (edge_q.size() != 0 || async_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d edge and %0d async expectations left, expected 0",
               edge_q.size(), async_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
